// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: FSM state
// encoding, access-size codes and the size-to-byte-count decode.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    // Access size codes carried on mem_state_i (2'b10 decodes as a word).
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b11;

    // Instruction fetches are always full words.
    localparam logic [2:0] N_FETCH = 3'd4;

    // Number of bytes moved for a given size code.
    function automatic logic [2:0] byte_count(input logic [1:0] size);
        case (size)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller. Serves instruction fetches and data
// loads/stores over an 8-bit synchronous RAM, one byte per cycle,
// little-endian lane order. Loads are zero-extended.
//
// Request handshake: there is no ready output. A request is taken in any
// cycle the controller is IDLE (write > read > fetch); the requester keeps
// its request high until it sees the matching one-cycle done pulse.
// Address, size, data and source are captured at acceptance, so inputs
// may change freely afterwards. A request still high in the DONE cycle is
// ignored there and taken again in the following IDLE cycle.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_done_o,
    output logic [31:0] if_data_o,
    input  logic        mem_r_req_i,
    input  logic        mem_w_req_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_w_data_i,
    input  logic [1:0]  mem_state_i,
    output logic        mem_done_o,
    output logic [31:0] mem_r_data_o,
    output logic [31:0] ram_a_o,
    output logic [7:0]  ram_dout_o,
    output logic        ram_wr_o,
    input  logic [7:0]  ram_din_i
);

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  cnt;
    logic [2:0]  n_bytes;
    logic [2:0]  next_idx;
    logic [2:0]  prev_idx;
    logic        last_wr_byte;
    logic        last_rd_byte;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        fetch_q;
    logic [31:0] rd_asm;
    logic [31:0] rd_merged;
    logic        take_w;
    logic        take_r;
    logic        take_f;

    // Arbitration: only IDLE accepts, write beats read beats fetch.
    always_comb begin
        take_w = (state == ST_IDLE) && mem_w_req_i;
        take_r = (state == ST_IDLE) && !mem_w_req_i && mem_r_req_i;
        take_f = (state == ST_IDLE) && !mem_w_req_i && !mem_r_req_i && if_req_i;
    end

    // Byte position helpers; cnt is the byte presented this cycle.
    always_comb begin
        next_idx     = cnt + 3'd1;
        prev_idx     = cnt - 3'd1;
        last_wr_byte = (cnt == n_bytes - 3'd1);
        last_rd_byte = (cnt == n_bytes);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: reads need one extra cycle for the last RAM return.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (take_w) begin
                    state_nxt = ST_WRITE;
                end else if (take_r || take_f) begin
                    state_nxt = ST_READ;
                end
            end
            ST_WRITE: begin
                if (last_wr_byte) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_READ: begin
                if (last_rd_byte) begin
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: one done pulse in DONE, routed by the latched source.
    always_comb begin
        mem_done_o = (state == ST_DONE) && !fetch_q;
        if_done_o  = (state == ST_DONE) && fetch_q;
    end

    // Transaction context capture and byte counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= 3'd0;
            n_bytes <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            fetch_q <= 1'b0;
        end else begin
            if (take_w || take_r) begin
                addr_q  <= mem_addr_i;
                wdata_q <= mem_w_data_i;
                n_bytes <= byte_count(mem_state_i);
                fetch_q <= 1'b0;
            end else if (take_f) begin
                addr_q  <= if_addr_i;
                n_bytes <= N_FETCH;
                fetch_q <= 1'b1;
            end
            if (state == ST_READ || state == ST_WRITE) begin
                cnt <= cnt + 3'd1;
            end else begin
                cnt <= 3'd0;
            end
        end
    end

    // Registered RAM port: byte 0 goes out straight from the request,
    // later bytes from the latched context; address adds wrap at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_a_o    <= 32'd0;
            ram_dout_o <= 8'd0;
            ram_wr_o   <= 1'b0;
        end else if (take_w) begin
            ram_a_o    <= mem_addr_i;
            ram_dout_o <= mem_w_data_i[7:0];
            ram_wr_o   <= 1'b1;
        end else if (take_r) begin
            ram_a_o  <= mem_addr_i;
            ram_wr_o <= 1'b0;
        end else if (take_f) begin
            ram_a_o  <= if_addr_i;
            ram_wr_o <= 1'b0;
        end else if (state == ST_WRITE && !last_wr_byte) begin
            ram_a_o    <= addr_q + {29'd0, next_idx};
            ram_dout_o <= wdata_q[{next_idx[1:0], 3'b000} +: 8];
            ram_wr_o   <= 1'b1;
        end else if (state == ST_READ && next_idx < n_bytes) begin
            ram_a_o  <= addr_q + {29'd0, next_idx};
            ram_wr_o <= 1'b0;
        end else begin
            ram_wr_o <= 1'b0;
        end
    end

    // Current read word with this cycle's returned byte dropped into its lane.
    always_comb begin
        rd_merged = rd_asm;
        rd_merged[{prev_idx[1:0], 3'b000} +: 8] = ram_din_i;
    end

    // Read lane assembly; the result register of the owning port is only
    // written when its read completes, so it holds across other traffic.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_asm       <= 32'd0;
            mem_r_data_o <= 32'd0;
            if_data_o    <= 32'd0;
        end else if (take_r || take_f) begin
            rd_asm <= 32'd0;
        end else if (state == ST_READ && cnt != 3'd0) begin
            rd_asm <= rd_merged;
            if (last_rd_byte) begin
                if (fetch_q) begin
                    if_data_o <= rd_merged;
                end else begin
                    mem_r_data_o <= rd_merged;
                end
            end
        end
    end

endmodule
